// File: rtl/my_lib.sv
// Shared types for the load/store unit: FSM states, access grains and response codes.
package my_lib;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    BYTE = 2'b01,
    HALF = 2'b10
  } mem_grain_e;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    ADDR    = 2'b01,
    TIMEOUT = 2'b10
  } lsu_err_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction
// with sign/zero extension, and misalignment detection for a 2-bit grain code.
module lsu_lane_align
  import my_lib::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_grain,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Grain decode; grain 2'b11 is treated as an illegal, misaligned access.
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0000_0000;
    o_rdata      = 32'h0000_0000;
    o_misaligned = 1'b0;
    w_half       = 16'h0000;
    w_byte       = 8'h00;
    case (i_grain)
      WORD: begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = i_rdata;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      HALF: begin
        if (i_addr_lo[1]) begin
          o_be   = 4'b1100;
          w_half = i_rdata[31:16];
        end else begin
          o_be   = 4'b0011;
          w_half = i_rdata[15:0];
        end
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{i_sign & w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      BYTE: begin
        o_be = 4'b0001 << i_addr_lo;
        case (i_addr_lo)
          2'b00:   w_byte = i_rdata[7:0];
          2'b01:   w_byte = i_rdata[15:8];
          2'b10:   w_byte = i_rdata[23:16];
          2'b11:   w_byte = i_rdata[31:24];
          default: w_byte = 8'h00;
        endcase
        o_wdata      = {4{i_wdata[7:0]}};
        o_rdata      = {{24{i_sign & w_byte[7]}}, w_byte};
        o_misaligned = 1'b0;
      end
      default: begin
        o_misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, stalls until the response.
// Optional macro LSU_TRACE_EN prints store and address-error trace lines.
module load_store_unit
  import my_lib::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_grain,
  input  logic        req_sign,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  r_state;
  logic [TO_W-1:0] r_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_write;
  logic [1:0]  r_grain;
  logic        r_sign;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  lsu_err_e    r_resp_error;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;

  logic [1:0]  w_addr_lo;
  logic [1:0]  w_grain;
  logic        w_sign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_misaligned;
  logic [TO_W-1:0] w_cnt_inc;

  // In IDLE the lane logic sees the incoming request; afterwards the captured one.
  assign w_addr_lo = (r_state == IDLE) ? req_addr[1:0] : r_addr[1:0];
  assign w_grain   = (r_state == IDLE) ? req_grain     : r_grain;
  assign w_sign    = (r_state == IDLE) ? req_sign      : r_sign;
  assign w_cnt_inc = r_cnt + TO_W'(1);

  lsu_lane_align u_lane_align (
    .i_addr_lo    (w_addr_lo),
    .i_grain      (w_grain),
    .i_sign       (w_sign),
    .i_wdata      (req_wdata),
    .i_rdata      (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_misaligned)
  );

  // Transaction FSM with all interface outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pc         <= 32'h0000_0000;
      r_addr       <= 32'h0000_0000;
      r_write      <= 1'b0;
      r_grain      <= 2'b00;
      r_sign       <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_error <= OK;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_pc        <= req_pc;
            r_addr      <= req_addr;
            r_write     <= req_write;
            r_grain     <= req_grain;
            r_sign      <= req_sign;
            r_req_ready <= 1'b0;
            if (w_misaligned) begin
              r_state      <= DONE;
              r_resp_valid <= 1'b1;
              r_resp_error <= ADDR;
              r_resp_rdata <= 32'h0000_0000;
            end else begin
              r_state     <= ISSUE;
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_write;
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            if (mem_rvalid) begin
              r_state      <= DONE;
              r_resp_valid <= 1'b1;
              r_resp_error <= OK;
              r_resp_rdata <= r_write ? 32'h0000_0000 : w_rdata;
            end else begin
              r_state <= WAIT;
              r_cnt   <= '0;
            end
          end
        end
        WAIT: begin
          // A response arriving on the timeout cycle still completes normally.
          if (mem_rvalid) begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_resp_error <= OK;
            r_resp_rdata <= r_write ? 32'h0000_0000 : w_rdata;
          end else if (w_cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_resp_error <= TIMEOUT;
            r_resp_rdata <= 32'h0000_0000;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_error <= OK;
          r_resp_rdata <= 32'h0000_0000;
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_mem_req    <= 1'b0;
        end
      endcase
    end
  end

`ifdef LSU_TRACE_EN
  // Trace completed stores and address exceptions as the response is presented.
  always_ff @(posedge clock) begin
    if (reset && (r_state == DONE)) begin
      if (r_resp_error == ADDR) begin
        $display("@%h: *%h SignalException AddressError", r_pc, r_addr);
      end else if (r_write && (r_resp_error == OK)) begin
        $display("@%h: *%h <= %h", r_pc, r_mem_addr, r_mem_wdata);
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{r_pc, r_addr[31:2]};
`endif

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout (4 cycles).
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [1:0]  req_grain;
  logic        req_sign;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_grain  (req_grain),
    .req_sign   (req_sign),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input logic [1:0] grain, input logic sgn);
    req_valid = 1'b1;
    req_pc    = pc;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    req_grain = grain;
    req_sign  = sgn;
    tick();
    req_valid = 1'b0;
  endtask

  // Accept, then grant and respond in the same ISSUE cycle; checks the response.
  task automatic quick_load(input string tag, input logic [31:0] addr, input logic [1:0] grain,
                            input logic sgn, input logic [31:0] rd, input logic [31:0] exp);
    issue(32'h0000_2000, addr, 1'b0, 32'h0, grain, sgn);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_err"}, {30'b0, resp_error}, 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_pc = 32'h0; req_addr = 32'h0; req_write = 1'b0;
    req_wdata = 32'h0; req_grain = 2'b00; req_sign = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    reset = 1'b1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_memreq", {31'b0, mem_req}, 32'd0);
    check("rst_be", {28'b0, mem_be}, 32'd0);
    check("rst_err", {30'b0, resp_error}, 32'd0);
    tick();

    // Store byte 0xA5 to 0x103, gnt+rvalid in the first ISSUE cycle
    issue(32'h0000_1000, 32'h0000_0103, 1'b1, 32'h0000_00A5, 2'b01, 1'b0);
    check("sb_memreq", {31'b0, mem_req}, 32'd1);
    check("sb_we", {31'b0, mem_we}, 32'd1);
    check("sb_addr", mem_addr, 32'h0000_0100);
    check("sb_be", {28'b0, mem_be}, 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_ready", {31'b0, req_ready}, 32'd0);
    check("sb_valid_early", {31'b0, resp_valid}, 32'd0);
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("sb_valid", {31'b0, resp_valid}, 32'd1);
    check("sb_err", {30'b0, resp_error}, 32'd0);
    check("sb_rdata", resp_rdata, 32'h0);
    check("sb_memreq_drop", {31'b0, mem_req}, 32'd0);
    tick();
    check("sb_pulse", {31'b0, resp_valid}, 32'd0);
    check("sb_ready_back", {31'b0, req_ready}, 32'd1);

    // Half store to upper half
    issue(32'h0000_1004, 32'h0000_020E, 1'b1, 32'h1234_CAFE, 2'b10, 1'b0);
    check("sh_be", {28'b0, mem_be}, 32'hC);
    check("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
    check("sh_addr", mem_addr, 32'h0000_020C);
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("sh_valid", {31'b0, resp_valid}, 32'd1);
    tick();

    // Loads with lane extraction and extension
    issue(32'h0000_1008, 32'h0000_0202, 1'b0, 32'h0, 2'b10, 1'b1);
    check("lh_be", {28'b0, mem_be}, 32'hC);
    check("lh_we", {31'b0, mem_we}, 32'd0);
    check("lh_addr", mem_addr, 32'h0000_0200);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("lh_s_rdata", resp_rdata, 32'hFFFF_8001);
    tick();
    quick_load("lhu", 32'h0000_0202, 2'b10, 1'b0, 32'h8001_1234, 32'h0000_8001);
    quick_load("lh_lo", 32'h0000_0200, 2'b10, 1'b1, 32'h8001_1234, 32'h0000_1234);
    quick_load("lb_s", 32'h0000_0101, 2'b01, 1'b1, 32'h1234_8078, 32'hFFFF_FF80);
    quick_load("lbu", 32'h0000_0101, 2'b01, 1'b0, 32'h1234_8078, 32'h0000_0080);
    quick_load("lb3", 32'h0000_0103, 2'b01, 1'b1, 32'h1234_8078, 32'h0000_0012);
    quick_load("lw", 32'h0000_0104, 2'b00, 1'b1, 32'h8765_4321, 32'h8765_4321);

    // Misaligned word, misaligned half and illegal grain
    issue(32'h0000_100C, 32'h0000_0105, 1'b0, 32'h0, 2'b00, 1'b0);
    check("mis_w_valid", {31'b0, resp_valid}, 32'd1);
    check("mis_w_err", {30'b0, resp_error}, 32'd1);
    check("mis_w_memreq", {31'b0, mem_req}, 32'd0);
    check("mis_w_rdata", resp_rdata, 32'h0);
    tick();
    check("mis_w_pulse", {31'b0, resp_valid}, 32'd0);
    check("mis_w_memreq2", {31'b0, mem_req}, 32'd0);
    issue(32'h0000_1010, 32'h0000_0101, 1'b1, 32'h0, 2'b10, 1'b0);
    check("mis_h_err", {30'b0, resp_error}, 32'd1);
    check("mis_h_memreq", {31'b0, mem_req}, 32'd0);
    tick();
    issue(32'h0000_1014, 32'h0000_0100, 1'b0, 32'h0, 2'b11, 1'b0);
    check("ill_err", {30'b0, resp_error}, 32'd1);
    check("ill_valid", {31'b0, resp_valid}, 32'd1);
    tick();

    // Grant held off 5 cycles; mem_* stable; rvalid 3 cycles after gnt
    issue(32'h0000_1018, 32'h0000_0300, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_req", {31'b0, mem_req}, 32'd1);
      check("hold_we", {31'b0, mem_we}, 32'd1);
      check("hold_addr", mem_addr, 32'h0000_0300);
      check("hold_be", {28'b0, mem_be}, 32'hF);
      check("hold_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("wait_req", {31'b0, mem_req}, 32'd0);
    tick(); tick();
    check("wait_novalid", {31'b0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("wait_st_valid", {31'b0, resp_valid}, 32'd1);
    check("wait_st_err", {30'b0, resp_error}, 32'd0);
    check("wait_st_rdata", resp_rdata, 32'h0);
    tick();

    issue(32'h0000_101C, 32'h0000_0304, 1'b0, 32'h0, 2'b00, 1'b0);
    tick(); tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("wait_ld_valid", {31'b0, resp_valid}, 32'd1);
    check("wait_ld_rdata", resp_rdata, 32'hDEAD_BEEF);
    tick();

    // Timeout: no rvalid after gnt, error 10 after 4 WAIT cycles
    issue(32'h0000_1020, 32'h0000_0400, 1'b0, 32'h0, 2'b00, 1'b0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_pending", {31'b0, resp_valid}, 32'd0);
    end
    tick();
    check("to_valid", {31'b0, resp_valid}, 32'd1);
    check("to_err", {30'b0, resp_error}, 32'd2);
    check("to_rdata", resp_rdata, 32'h0);
    tick();
    check("to_ready", {31'b0, req_ready}, 32'd1);

    // rvalid on the timeout cycle wins
    issue(32'h0000_1024, 32'h0000_0400, 1'b0, 32'h0, 2'b00, 1'b0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick(); tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("race_valid", {31'b0, resp_valid}, 32'd1);
    check("race_err", {30'b0, resp_error}, 32'd0);
    check("race_rdata", resp_rdata, 32'h5555_AAAA);
    tick();

    // Reset during ISSUE drops mem_req
    issue(32'h0000_1028, 32'h0000_0500, 1'b0, 32'h0, 2'b00, 1'b0);
    check("ri_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("ri_req_drop", {31'b0, mem_req}, 32'd0);
    check("ri_ready", {31'b0, req_ready}, 32'd1);

    // Reset during WAIT, then a stray rvalid in IDLE
    issue(32'h0000_102C, 32'h0000_0500, 1'b0, 32'h0, 2'b00, 1'b0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rw_ready", {31'b0, req_ready}, 32'd1);
    check("rw_valid", {31'b0, resp_valid}, 32'd0);
    tick();
    check("rw_valid2", {31'b0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    check("stray_valid", {31'b0, resp_valid}, 32'd0);
    check("stray_ready", {31'b0, req_ready}, 32'd1);
    tick();
    check("stray_valid2", {31'b0, resp_valid}, 32'd0);
    quick_load("post_rst", 32'h0000_0500, 2'b00, 1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the CPU data-memory interface. Takes one load/store per handshake from the MEM stage.
- Checks alignment, then drives a word-addressed memory port with byte enables and lane-replicated store data.
- Waits for the response, then returns load data that has been lane-extracted and sign- or zero-extended.
- Multi-cycle: the pipeline stalls on req_ready until resp_valid.

Parameters:
- TIMEOUT_CYCLES, 64, cycles to wait in WAIT for mem_rvalid before flagging a bus timeout (1..255).
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override).

Ports:
- clock, input, 1, system clock. One clock; reset is synchronous and active-low.
- reset, input, 1, synchronous active-low reset.
- req_valid, input, 1, pipeline request valid.
- req_ready, output, 1, unit can accept a request (high only in IDLE).
- req_pc, input, 32, PC of the issuing instruction (trace/exception reporting).
- req_addr, input, 32, byte address.
- req_write, input, 1, 1 = store, 0 = load.
- req_wdata, input, 32, store data (low bits used for byte/half).
- req_grain, input, 2, 00 word, 01 byte, 10 half, 11 illegal.
- req_sign, input, 1, sign-extend load result.
- resp_valid, output, 1, one-cycle completion pulse.
- resp_rdata, output, 32, extended load data; 0 for stores and errors.
- resp_error, output, 2, 00 ok, 01 address error, 10 bus timeout.
- mem_req, output, 1, memory request, held until mem_gnt.
- mem_we, output, 1, write strobe.
- mem_addr, output, 32, {addr[31:2],2'b00}.
- mem_be, output, 4, byte enables.
- mem_wdata, output, 32, lane-replicated store data.
- mem_gnt, input, 1, memory accepted request.
- mem_rvalid, input, 1, response (read data or write ack).
- mem_rdata, input, 32, read word.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - All outputs 0 except req_ready=1.
  - Timeout counter and captured fields cleared.
  - Reset mid-transaction abandons it; mem_req drops after that edge.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture pc/addr/write/wdata/grain/sign.
  - Misaligned access goes to DONE with error 01 and no memory access. Misaligned means: word with addr[1:0]!=0, half with addr[0]!=0, or grain 11.
  - Otherwise go to ISSUE.
  - mem_rvalid seen in IDLE is ignored.
- ISSUE:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata stay stable until mem_gnt.
  - On mem_gnt with mem_rvalid in the same cycle, go to DONE.
  - On mem_gnt alone, go to WAIT and clear the counter.
  - ISSUE itself has no timeout.
- WAIT:
  - mem_req=0. Counter increments each cycle.
  - On mem_rvalid, capture mem_rdata and go to DONE.
  - When the counter reaches TIMEOUT_CYCLES with no rvalid, go to DONE with error 10.
  - If rvalid and timeout occur in the same cycle, rvalid wins.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. Back-to-back requests have one idle cycle minimum between them.
- Minimum latency, accept to resp_valid, is 2 cycles: accept edge, ISSUE (gnt+rvalid), DONE.
- Byte enables and store data:
  - Word: be=1111, wdata as-is.
  - Half: be=0011<<(2*addr[1]), wdata={2{wdata[15:0]}}.
  - Byte: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
- Load extract:
  - Byte lane = rdata[8*addr[1:0] +: 8].
  - Half lane = rdata[16*addr[1] +: 16].
  - Upper bits = req_sign & lane MSB. Word returned unchanged.

Optional Feature:
- Macro LSU_TRACE_EN.
- When defined:
  - Each successful store in DONE prints "@<pc>: *<word addr> <= <mem_wdata>" via $display.
  - Address errors print "@<pc>: *<addr> SignalException AddressError".
  - Simulation is not stopped.
- When undefined: no $display, and behaviour is identical.

Decomposition:
- Shared package my_lib gets:
  - lsu_state_e (IDLE/ISSUE/WAIT/DONE).
  - mem_grain_e (WORD=2'b00, BYTE=2'b01, HALF=2'b10).
  - lsu_err_e (OK, ADDR, TIMEOUT).
- One combinational sub-module, lsu_lane_align, provides the be/wdata generation, load extraction/extension and misalignment detect.

Test Plan:
- Store byte 0xA5 to 0x103, gnt+rvalid same cycle -> mem_be=1000, mem_wdata=A5A5A5A5, mem_addr=0x100, resp_valid 2 cycles after accept, error 00.
- Load half signed from 0x202 with mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001. Unsigned -> 0x00008001.
- Load word from 0x105 -> resp_error=01, mem_req never asserted, resp_valid one cycle after accept.
- gnt delayed 5 cycles -> mem_req and all mem_* outputs stable throughout. rvalid 3 cycles after gnt -> correct data.
- With TIMEOUT_CYCLES=4, no rvalid after gnt -> resp_error=10 exactly 4 cycles into WAIT, resp_rdata=0.
- reset=0 asserted during WAIT -> next cycle state IDLE, req_ready=1, no resp_valid. Later stray rvalid ignored.
